// File: rtl/psum_mem_arbiter.sv
// Purpose: round-robin arbiter sharing one psum memory port (write + read) between two requesters.
// Latency: 1 cycle request-to-memory, 1 cycle memory-return-to-requester.
// Backpressure: wrdy/rrdy are combinational grants; reads stall while MAX_OUTSTANDING are in flight.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   rqN_wadd/wren/idat -> wrdy   write request channel of requester N (N = 0,1)
//   rqN_radd/rden      -> rrdy   read request channel of requester N
//   rqN_odat/oval                read return to requester N (registered, 1-cycle pulse)
//   memctrl0_w*/r*               registered memory write/read channels
//   memctrl0_odat/oval           in-order memory read return
//   o_rd_outstanding             reads issued and not yet returned
//   o_err                        sticky flag: memory return with nothing outstanding

// Owner-tag FIFO: remembers which requester issued each in-flight read.
// Latency: head is visible combinationally; push/pop take effect at the clock edge.
// Backpressure: none internally; the caller never pushes when full or pops when empty.
module psum_tag_fifo #(
    parameter int DEPTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_push,
    input  logic i_din,
    input  logic i_pop,
    output logic o_dout
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic          r_mem [DEPTH];
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;

    // Storage carries no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wp] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (i_push) begin
                r_wp <= r_wp + 1'b1;
            end
            if (i_pop) begin
                r_rp <= r_rp + 1'b1;
            end
        end
    end

    assign o_dout = r_mem[r_rp];
endmodule

module psum_mem_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 8,
    parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] rq0_wadd,
    input  logic                  rq0_wren,
    input  logic [DATA_WIDTH-1:0] rq0_idat,
    output logic                  rq0_wrdy,
    input  logic [ADDR_WIDTH-1:0] rq0_radd,
    input  logic                  rq0_rden,
    output logic                  rq0_rrdy,
    output logic [DATA_WIDTH-1:0] rq0_odat,
    output logic                  rq0_oval,
    input  logic [ADDR_WIDTH-1:0] rq1_wadd,
    input  logic                  rq1_wren,
    input  logic [DATA_WIDTH-1:0] rq1_idat,
    output logic                  rq1_wrdy,
    input  logic [ADDR_WIDTH-1:0] rq1_radd,
    input  logic                  rq1_rden,
    output logic                  rq1_rrdy,
    output logic [DATA_WIDTH-1:0] rq1_odat,
    output logic                  rq1_oval,
    output logic [ADDR_WIDTH-1:0] memctrl0_wadd,
    output logic                  memctrl0_wren,
    output logic [DATA_WIDTH-1:0] memctrl0_idat,
    output logic [ADDR_WIDTH-1:0] memctrl0_radd,
    output logic                  memctrl0_rden,
    input  logic [DATA_WIDTH-1:0] memctrl0_odat,
    input  logic                  memctrl0_oval,
    output logic [CNT_WIDTH-1:0]  o_rd_outstanding,
    output logic                  o_err
);
    localparam logic [CNT_WIDTH-1:0] MAX_C = CNT_WIDTH'(MAX_OUTSTANDING);

    // Round-robin pointers: index of the requester favoured on the next contended cycle.
    logic                  r_wptr;
    logic                  r_rptr;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic                  r_err;
    logic                  r_mwren;
    logic [ADDR_WIDTH-1:0] r_mwadd;
    logic [DATA_WIDTH-1:0] r_midat;
    logic                  r_mrden;
    logic [ADDR_WIDTH-1:0] r_mradd;
    logic                  r_oval0;
    logic                  r_oval1;
    logic [DATA_WIDTH-1:0] r_odat0;
    logic [DATA_WIDTH-1:0] r_odat1;

    logic w_wgnt0;
    logic w_wgnt1;
    logic w_rgnt0;
    logic w_rgnt1;
    logic w_rd_room;
    logic w_racc;
    logic w_ret;
    logic w_head;

    // Grants look only at requests, pointers and the registered count, so nothing
    // from the memory return path reaches a ready. A full counter therefore blocks
    // reads for the cycle in which a return arrives; the slot frees up next cycle.
    assign w_rd_room = (r_cnt < MAX_C);
    assign w_wgnt0   = ~rst & rq0_wren & (~rq1_wren | ~r_wptr);
    assign w_wgnt1   = ~rst & rq1_wren & (~rq0_wren |  r_wptr);
    assign w_rgnt0   = ~rst & w_rd_room & rq0_rden & (~rq1_rden | ~r_rptr);
    assign w_rgnt1   = ~rst & w_rd_room & rq1_rden & (~rq0_rden |  r_rptr);
    assign w_racc    = w_rgnt0 | w_rgnt1;
    // A return is only honoured when a read is actually outstanding.
    assign w_ret     = memctrl0_oval & (r_cnt != '0);

    psum_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk    (clk),
        .rst    (rst),
        .i_push (w_racc),
        .i_din  (w_rgnt1),
        .i_pop  (w_ret),
        .o_dout (w_head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_mwren <= 1'b0;
            r_mwadd <= '0;
            r_midat <= '0;
            r_mrden <= 1'b0;
            r_mradd <= '0;
            r_oval0 <= 1'b0;
            r_oval1 <= 1'b0;
            r_odat0 <= '0;
            r_odat1 <= '0;
        end else begin
            // Contended grant hands priority to the loser; exactly one side wins here.
            if (rq0_wren & rq1_wren) begin
                r_wptr <= w_wgnt0;
            end
            if (rq0_rden & rq1_rden & w_racc) begin
                r_rptr <= w_rgnt0;
            end

            r_mwren <= w_wgnt0 | w_wgnt1;
            if (w_wgnt0) begin
                r_mwadd <= rq0_wadd;
                r_midat <= rq0_idat;
            end else if (w_wgnt1) begin
                r_mwadd <= rq1_wadd;
                r_midat <= rq1_idat;
            end

            r_mrden <= w_racc;
            if (w_rgnt0) begin
                r_mradd <= rq0_radd;
            end else if (w_rgnt1) begin
                r_mradd <= rq1_radd;
            end

            case ({w_racc, w_ret})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase

            // Route the in-order return to the owner at the tag FIFO head.
            r_oval0 <= w_ret & ~w_head;
            r_oval1 <= w_ret &  w_head;
            if (w_ret & ~w_head) begin
                r_odat0 <= memctrl0_odat;
            end
            if (w_ret & w_head) begin
                r_odat1 <= memctrl0_odat;
            end

            if (memctrl0_oval & (r_cnt == '0)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign rq0_wrdy         = w_wgnt0;
    assign rq1_wrdy         = w_wgnt1;
    assign rq0_rrdy         = w_rgnt0;
    assign rq1_rrdy         = w_rgnt1;
    assign rq0_oval         = r_oval0;
    assign rq1_oval         = r_oval1;
    assign rq0_odat         = r_odat0;
    assign rq1_odat         = r_odat1;
    assign memctrl0_wren    = r_mwren;
    assign memctrl0_wadd    = r_mwadd;
    assign memctrl0_idat    = r_midat;
    assign memctrl0_rden    = r_mrden;
    assign memctrl0_radd    = r_mradd;
    assign o_rd_outstanding = r_cnt;
    assign o_err            = r_err;
endmodule

// File: tb/tb_psum_mem_arbiter.sv
module tb_psum_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MO = 8;
    localparam int CW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [AW-1:0] rq0_wadd, rq1_wadd, rq0_radd, rq1_radd;
    logic          rq0_wren, rq1_wren, rq0_rden, rq1_rden;
    logic [DW-1:0] rq0_idat, rq1_idat;
    logic          rq0_wrdy, rq1_wrdy, rq0_rrdy, rq1_rrdy;
    logic [DW-1:0] rq0_odat, rq1_odat;
    logic          rq0_oval, rq1_oval;
    logic [AW-1:0] memctrl0_wadd, memctrl0_radd;
    logic          memctrl0_wren, memctrl0_rden;
    logic [DW-1:0] memctrl0_idat, memctrl0_odat;
    logic          memctrl0_oval;
    logic [CW-1:0] o_rd_outstanding;
    logic          o_err;

    psum_mem_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .rq0_wadd(rq0_wadd), .rq0_wren(rq0_wren), .rq0_idat(rq0_idat), .rq0_wrdy(rq0_wrdy),
        .rq0_radd(rq0_radd), .rq0_rden(rq0_rden), .rq0_rrdy(rq0_rrdy),
        .rq0_odat(rq0_odat), .rq0_oval(rq0_oval),
        .rq1_wadd(rq1_wadd), .rq1_wren(rq1_wren), .rq1_idat(rq1_idat), .rq1_wrdy(rq1_wrdy),
        .rq1_radd(rq1_radd), .rq1_rden(rq1_rden), .rq1_rrdy(rq1_rrdy),
        .rq1_odat(rq1_odat), .rq1_oval(rq1_oval),
        .memctrl0_wadd(memctrl0_wadd), .memctrl0_wren(memctrl0_wren), .memctrl0_idat(memctrl0_idat),
        .memctrl0_radd(memctrl0_radd), .memctrl0_rden(memctrl0_rden),
        .memctrl0_odat(memctrl0_odat), .memctrl0_oval(memctrl0_oval),
        .o_rd_outstanding(o_rd_outstanding), .o_err(o_err)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: favoured requester per channel, queue of read owners,
    // and the values every registered output should show.
    int            m_wfav, m_rfav;
    int            m_owners[$];
    logic          m_mwren, m_mrden, m_oval0, m_oval1, m_err;
    logic [AW-1:0] m_mwadd, m_mradd;
    logic [DW-1:0] m_midat, m_odat0, m_odat1;
    logic          m_gw0, m_gw1, m_gr0, m_gr1;

    // Behavioural memory: addresses it has been asked to read, in order.
    logic [AW-1:0] mem_q[$];
    bit            mem_auto = 0;

    function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
        return a * 32'd7 + 32'h1000_0003;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_wfav = 0; m_rfav = 0;
        m_owners.delete();
        m_mwren = 0; m_mrden = 0; m_oval0 = 0; m_oval1 = 0; m_err = 0;
        m_mwadd = '0; m_mradd = '0; m_midat = '0; m_odat0 = '0; m_odat1 = '0;
    endtask

    // Grants from the arbitration rule: a lone requester wins, a contended
    // cycle goes to the favoured one, reads need a free outstanding slot.
    task automatic model_grants();
        bit room;
        room  = m_owners.size() < MO;
        m_gw0 = 0; m_gw1 = 0; m_gr0 = 0; m_gr1 = 0;
        if (!rst) begin
            if (rq0_wren && rq1_wren) begin
                if (m_wfav == 0) m_gw0 = 1; else m_gw1 = 1;
            end else begin
                m_gw0 = rq0_wren; m_gw1 = rq1_wren;
            end
            if (room) begin
                if (rq0_rden && rq1_rden) begin
                    if (m_rfav == 0) m_gr0 = 1; else m_gr1 = 1;
                end else begin
                    m_gr0 = rq0_rden; m_gr1 = rq1_rden;
                end
            end
        end
    endtask

    task automatic model_edge();
        int own;
        if (rst) begin
            model_reset();
            return;
        end
        m_mwren = m_gw0 | m_gw1;
        if (m_gw0) begin m_mwadd = rq0_wadd; m_midat = rq0_idat; end
        if (m_gw1) begin m_mwadd = rq1_wadd; m_midat = rq1_idat; end
        if (rq0_wren && rq1_wren) m_wfav = m_gw0 ? 1 : 0;
        m_mrden = m_gr0 | m_gr1;
        if (m_gr0) m_mradd = rq0_radd;
        if (m_gr1) m_mradd = rq1_radd;
        if (rq0_rden && rq1_rden && (m_gr0 || m_gr1)) m_rfav = m_gr0 ? 1 : 0;
        m_oval0 = 0; m_oval1 = 0;
        if (memctrl0_oval) begin
            if (m_owners.size() > 0) begin
                own = m_owners.pop_front();
                if (own == 0) begin m_oval0 = 1; m_odat0 = memctrl0_odat; end
                else          begin m_oval1 = 1; m_odat1 = memctrl0_odat; end
            end else begin
                m_err = 1;
            end
        end
        if (m_gr0) m_owners.push_back(0);
        if (m_gr1) m_owners.push_back(1);
    endtask

    // One clock: inputs were set at posedge+1; check at posedge+3, then advance.
    task automatic tick();
        if (mem_auto) begin
            memctrl0_oval = 0;
            if (mem_q.size() > 0 && $urandom_range(0, 2) != 0) begin
                memctrl0_oval = 1;
                memctrl0_odat = mem_data(mem_q.pop_front());
            end
        end
        #2;
        model_grants();
        chk("wrdy0", rq0_wrdy, m_gw0);
        chk("wrdy1", rq1_wrdy, m_gw1);
        chk("rrdy0", rq0_rrdy, m_gr0);
        chk("rrdy1", rq1_rrdy, m_gr1);
        chk("mwren", memctrl0_wren, m_mwren);
        chk("mwadd", memctrl0_wadd, m_mwadd);
        chk("midat", memctrl0_idat, m_midat);
        chk("mrden", memctrl0_rden, m_mrden);
        chk("mradd", memctrl0_radd, m_mradd);
        chk("oval0", rq0_oval, m_oval0);
        chk("oval1", rq1_oval, m_oval1);
        chk("odat0", rq0_odat, m_odat0);
        chk("odat1", rq1_odat, m_odat1);
        chk("count", o_rd_outstanding, m_owners.size());
        chk("err", o_err, m_err);
        model_edge();
        @(posedge clk);
        #1;
        if (memctrl0_rden) mem_q.push_back(memctrl0_radd);
    endtask

    task automatic mem_return();
        memctrl0_oval = 1;
        memctrl0_odat = mem_data(mem_q.pop_front());
        tick();
        memctrl0_oval = 0;
    endtask

    task automatic idle_inputs();
        rq0_wren = 0; rq1_wren = 0; rq0_rden = 0; rq1_rden = 0;
        memctrl0_oval = 0;
    endtask

    initial begin
        rst = 1;
        rq0_wadd = '0; rq1_wadd = '0; rq0_radd = '0; rq1_radd = '0;
        rq0_idat = '0; rq1_idat = '0; memctrl0_odat = '0;
        idle_inputs();
        model_reset();
        @(posedge clk); #1;

        // Reset state
        tick(); tick();
        rst = 0;
        tick();
        chk("rst_cnt", o_rd_outstanding, 0);

        // Single write
        rq0_wren = 1; rq0_wadd = 32'h10; rq0_idat = 32'hAB;
        tick();
        rq0_wren = 0;
        chk("sw_wren", memctrl0_wren, 1);
        chk("sw_wadd", memctrl0_wadd, 32'h10);
        chk("sw_idat", memctrl0_idat, 32'hAB);
        tick();
        chk("sw_wren_off", memctrl0_wren, 0);

        // Contended writes alternate starting with requester 0
        rq0_wren = 1; rq1_wren = 1;
        rq0_wadd = 32'h100; rq1_wadd = 32'h200;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("cw_order", memctrl0_wadd, (i % 2 == 0) ? 32'h100 : 32'h200);
        end
        idle_inputs();
        tick();

        // Interleaved reads, returned in order 3 cycles later
        rq0_rden = 1; rq0_radd = 32'h1; tick(); rq0_rden = 0;
        rq1_rden = 1; rq1_radd = 32'h2; tick(); rq1_rden = 0;
        rq0_rden = 1; rq0_radd = 32'h3; tick(); rq0_rden = 0;
        tick(); tick();
        mem_return(); tick();
        chk("ir_d1", rq0_odat, mem_data(32'h1));
        mem_return(); tick();
        chk("ir_d2", rq1_odat, mem_data(32'h2));
        mem_return(); tick();
        chk("ir_d3", rq0_odat, mem_data(32'h3));
        tick();

        // Backpressure at MAX_OUTSTANDING
        rq0_rden = 1;
        for (int i = 0; i < MO + 2; i++) begin
            rq0_radd = 32'h40 + i;
            tick();
        end
        chk("bp_full", o_rd_outstanding, MO);
        mem_return();
        chk("bp_after_ret", o_rd_outstanding, MO - 1);
        tick();
        chk("bp_refill", o_rd_outstanding, MO);
        rq0_rden = 0;
        mem_auto = 1;
        for (int i = 0; i < 40; i++) tick();
        mem_auto = 0;
        chk("bp_drained", o_rd_outstanding, 0);

        // Stray return sets a sticky error
        memctrl0_odat = 32'hDEAD;
        memctrl0_oval = 1; tick(); memctrl0_oval = 0;
        chk("stray_err", o_err, 1);
        tick(); tick();
        chk("stray_sticky", o_err, 1);

        // Reset with reads in flight; late returns are strays
        rst = 1; tick(); rst = 0;
        rq1_rden = 1;
        for (int i = 0; i < 3; i++) begin
            rq1_radd = 32'h80 + i;
            tick();
        end
        rq1_rden = 0;
        tick();
        rst = 1; tick(); rst = 0;
        chk("mid_cnt", o_rd_outstanding, 0);
        for (int i = 0; i < 3; i++) mem_return();
        tick();
        chk("mid_err", o_err, 1);

        // Randomized traffic with a behavioural memory
        rst = 1; tick(); rst = 0;
        mem_q.delete();
        mem_auto = 1;
        for (int i = 0; i < 600; i++) begin
            if (!rq0_wren || m_gw0) begin
                rq0_wren = ($urandom_range(0, 3) != 0);
                rq0_wadd = $urandom(); rq0_idat = $urandom();
            end
            if (!rq1_wren || m_gw1) begin
                rq1_wren = ($urandom_range(0, 3) != 0);
                rq1_wadd = $urandom(); rq1_idat = $urandom();
            end
            if (!rq0_rden || m_gr0) begin
                rq0_rden = ($urandom_range(0, 2) != 0);
                rq0_radd = $urandom();
            end
            if (!rq1_rden || m_gr1) begin
                rq1_rden = ($urandom_range(0, 2) != 0);
                rq1_radd = $urandom();
            end
            tick();
        end
        idle_inputs();
        for (int i = 0; i < 40; i++) tick();
        mem_auto = 0;
        chk("rand_drained", o_rd_outstanding, 0);
        chk("rand_no_err", o_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
